// File: rtl/spu32_cpu_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// spu32_cpu_regfile_ctrl
//
// Sequences every access to the CPU register file (spu32_cpu_registers:
// synchronous read with one cycle of latency, writes to x0 ignored). It
// arbitrates between the CPU decode/writeback port and a debug port. Debug
// starvation is bounded. When CLEAR_ON_RESET is set, x1..x31 are zeroed
// after reset.
//
// Parameters
//   CLEAR_ON_RESET    1: run the CLEAR sequence after reset, 0: start in IDLE
//   DBG_STARVE_LIMIT  consecutive CPU grants with debug pending before the
//                     debug port is forced through (>= 1)
//
// Ports
//   I_clk, I_reset                 clock, async active-high reset
//   I_cpu_req/we/rs1/rs2/rd/data   CPU access request and operands
//   O_cpu_ack, O_cpu_regval1/2     CPU completion pulse and read values
//   I_dbg_req/we/addr/data         debug access request and operands
//   O_dbg_ack, O_dbg_rdata         debug completion pulse and read value
//   O_busy                         high while the CLEAR sequence runs
//   O_rf_rs1/rs2/rd/data/re/we     registered register-file controls
//   I_rf_regval1/2                 register-file read data
//   O_state                        FSM state: 0 CLEAR, 1 IDLE, 2 ACCESS, 3 RESP
//
// Handshake (both ports): the requester raises req with its operands and
// holds them until it sees ack. Ack is a one-cycle pulse and the read data
// is valid only in that cycle. In the cycle after ack the requester either
// drops req or presents its next operation. A req that is high while ack is
// high is not treated as a new request. A request seen during CLEAR is not
// acked until CLEAR finishes.
// ---------------------------------------------------------------------------
module spu32_cpu_regfile_ctrl #(
   parameter bit CLEAR_ON_RESET   = 1'b1,
   parameter int DBG_STARVE_LIMIT = 4
) (
   input  logic        I_clk,
   input  logic        I_reset,
   input  logic        I_cpu_req,
   input  logic        I_cpu_we,
   input  logic [4:0]  I_cpu_rs1,
   input  logic [4:0]  I_cpu_rs2,
   input  logic [4:0]  I_cpu_rd,
   input  logic [31:0] I_cpu_data,
   output logic        O_cpu_ack,
   output logic [31:0] O_cpu_regval1,
   output logic [31:0] O_cpu_regval2,
   input  logic        I_dbg_req,
   input  logic        I_dbg_we,
   input  logic [4:0]  I_dbg_addr,
   input  logic [31:0] I_dbg_data,
   output logic        O_dbg_ack,
   output logic [31:0] O_dbg_rdata,
   output logic        O_busy,
   output logic [4:0]  O_rf_rs1,
   output logic [4:0]  O_rf_rs2,
   output logic [4:0]  O_rf_rd,
   output logic [31:0] O_rf_data,
   output logic        O_rf_re,
   output logic        O_rf_we,
   input  logic [31:0] I_rf_regval1,
   input  logic [31:0] I_rf_regval2,
   output logic [1:0]  O_state
);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_IDLE   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam int            CW         = $clog2(DBG_STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(DBG_STARVE_LIMIT);

   state_t        state;
   logic [5:0]    clr_k;        // next register to clear; bit 5 set once x31 is done
   logic [CW-1:0] starve_cnt;
   logic          grant_dbg;    // winner of the current access
   logic          grant_dbg_we; // debug access is a write
   logic          dbg_win;
   logic          cpu_win;

   // Debug wins when it is the only requester, or once the CPU has taken
   // DBG_STARVE_LIMIT grants in a row while debug was waiting.
   always_comb begin
      dbg_win = I_dbg_req && (!I_cpu_req || (starve_cnt == STARVE_MAX));
      cpu_win = I_cpu_req && !dbg_win;
   end

   // The regfile read data settles after the end edge of ACCESS. So the
   // registered ack gates it straight through during RESP. Registering the
   // data as well would cost a cycle. Outside RESP these outputs are zero.
   assign O_cpu_regval1 = O_cpu_ack ? I_rf_regval1 : 32'd0;
   assign O_cpu_regval2 = O_cpu_ack ? I_rf_regval2 : 32'd0;
   assign O_dbg_rdata   = (O_dbg_ack && !grant_dbg_we) ? I_rf_regval1 : 32'd0;
   assign O_state       = state;

   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         state        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         O_busy       <= CLEAR_ON_RESET;
         clr_k        <= 6'd1;
         starve_cnt   <= '0;
         grant_dbg    <= 1'b0;
         grant_dbg_we <= 1'b0;
         O_cpu_ack    <= 1'b0;
         O_dbg_ack    <= 1'b0;
         O_rf_rs1     <= 5'd0;
         O_rf_rs2     <= 5'd0;
         O_rf_rd      <= 5'd0;
         O_rf_data    <= 32'd0;
         O_rf_re      <= 1'b0;
         O_rf_we      <= 1'b0;
      end else begin
         O_cpu_ack <= 1'b0;
         O_dbg_ack <= 1'b0;

         // The starvation count only runs while debug is actually waiting.
         if (!I_dbg_req) begin
            starve_cnt <= '0;
         end else if (state == S_IDLE) begin
            if (dbg_win) begin
               starve_cnt <= '0;
            end else if (cpu_win && (starve_cnt != STARVE_MAX)) begin
               starve_cnt <= starve_cnt + CW'(1);
            end
         end

         case (state)
            S_CLEAR: begin
               if (!clr_k[5]) begin
                  O_rf_we   <= 1'b1;
                  O_rf_re   <= 1'b0;
                  O_rf_rd   <= clr_k[4:0];
                  O_rf_data <= 32'd0;
                  clr_k     <= clr_k + 6'd1;
               end else begin
                  O_rf_we <= 1'b0;
                  O_busy  <= 1'b0;
                  state   <= S_IDLE;
               end
            end

            S_IDLE: begin
               if (dbg_win) begin
                  grant_dbg    <= 1'b1;
                  grant_dbg_we <= I_dbg_we;
                  O_rf_rs1     <= I_dbg_we ? 5'd0 : I_dbg_addr;
                  O_rf_rs2     <= 5'd0;
                  O_rf_rd      <= I_dbg_we ? I_dbg_addr : 5'd0;
                  O_rf_data    <= I_dbg_data;
                  O_rf_re      <= !I_dbg_we;
                  O_rf_we      <= I_dbg_we;
                  state        <= S_ACCESS;
               end else if (cpu_win) begin
                  grant_dbg    <= 1'b0;
                  grant_dbg_we <= 1'b0;
                  O_rf_rs1     <= I_cpu_rs1;
                  O_rf_rs2     <= I_cpu_rs2;
                  O_rf_rd      <= I_cpu_rd;
                  O_rf_data    <= I_cpu_data;
                  O_rf_re      <= 1'b1;
                  O_rf_we      <= I_cpu_we;
                  state        <= S_ACCESS;
               end
            end

            // The regfile samples the enables at the end of this cycle. Reads
            // therefore return the value held before a same-cycle write.
            S_ACCESS: begin
               O_rf_re <= 1'b0;
               O_rf_we <= 1'b0;
               if (grant_dbg) begin
                  O_dbg_ack <= 1'b1;
               end else begin
                  O_cpu_ack <= 1'b1;
               end
               state <= S_RESP;
            end

            S_RESP: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spu32_cpu_regfile_ctrl.sv
module tb_spu32_cpu_regfile_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [4:0]  cpu_rs1 = 5'd0, cpu_rs2 = 5'd0, cpu_rd = 5'd0;
   logic [31:0] cpu_data = 32'd0;
   logic        cpu_ack;
   logic [31:0] cpu_regval1, cpu_regval2;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data = 32'd0;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        busy;
   logic [4:0]  rf_rs1, rf_rs2, rf_rd;
   logic [31:0] rf_data;
   logic        rf_re, rf_we;
   logic [31:0] rf_regval1 = 32'd0, rf_regval2 = 32'd0;
   logic [1:0]  state;

   spu32_cpu_regfile_ctrl #(.CLEAR_ON_RESET(1'b1), .DBG_STARVE_LIMIT(4)) dut (
      .I_clk(clk), .I_reset(rst),
      .I_cpu_req(cpu_req), .I_cpu_we(cpu_we), .I_cpu_rs1(cpu_rs1), .I_cpu_rs2(cpu_rs2),
      .I_cpu_rd(cpu_rd), .I_cpu_data(cpu_data),
      .O_cpu_ack(cpu_ack), .O_cpu_regval1(cpu_regval1), .O_cpu_regval2(cpu_regval2),
      .I_dbg_req(dbg_req), .I_dbg_we(dbg_we), .I_dbg_addr(dbg_addr), .I_dbg_data(dbg_data),
      .O_dbg_ack(dbg_ack), .O_dbg_rdata(dbg_rdata), .O_busy(busy),
      .O_rf_rs1(rf_rs1), .O_rf_rs2(rf_rs2), .O_rf_rd(rf_rd), .O_rf_data(rf_data),
      .O_rf_re(rf_re), .O_rf_we(rf_we),
      .I_rf_regval1(rf_regval1), .I_rf_regval2(rf_regval2), .O_state(state)
   );

   // ---------------- register file environment ----------------
   // Sync read with 1-cycle latency, writes to x0 dropped. Filled with
   // non-zero junk at the first edge so that the clear sequence is visible.
   logic [31:0] regs [32];
   logic        filled = 1'b0;
   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : (32'hA5A50000 | 32'(i));
         filled <= 1'b1;
      end else begin
         if (rf_re) begin
            rf_regval1 <= regs[rf_rs1];
            rf_regval2 <= regs[rf_rs2];
         end
         if (rf_we && (rf_rd != 5'd0)) regs[rf_rd] <= rf_data;
      end
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   // Register-file controls captured in the ACCESS cycle of the last access.
   logic        snap_re, snap_we;
   logic [4:0]  snap_rs1, snap_rs2, snap_rd;
   logic [31:0] snap_data;

   // ---------------- driver tasks ----------------
   task automatic cpu_access(input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] data,
                             output logic [31:0] v1, output logic [31:0] v2, output int lat);
      bit done = 1'b0;
      cpu_we = we; cpu_rs1 = rs1; cpu_rs2 = rs2; cpu_rd = rd; cpu_data = data; cpu_req = 1'b1;
      v1 = 32'd0; v2 = 32'd0; lat = 0;
      for (int c = 1; c <= 20 && !done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            snap_re = rf_re; snap_we = rf_we; snap_rs1 = rf_rs1; snap_rs2 = rf_rs2;
            snap_rd = rf_rd; snap_data = rf_data;
         end
         if (cpu_ack) begin
            done = 1'b1; lat = c; v1 = cpu_regval1; v2 = cpu_regval2;
         end
      end
      cpu_req = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL cpu_timeout: no O_cpu_ack within 20 cycles, required an ack");
      end
      @(negedge clk);
   endtask

   task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] data,
                             output logic [31:0] rdata, output int lat);
      bit done = 1'b0;
      dbg_we = we; dbg_addr = addr; dbg_data = data; dbg_req = 1'b1;
      rdata = 32'd0; lat = 0;
      for (int c = 1; c <= 20 && !done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            snap_re = rf_re; snap_we = rf_we; snap_rs1 = rf_rs1; snap_rs2 = rf_rs2;
            snap_rd = rf_rd; snap_data = rf_data;
         end
         if (dbg_ack) begin
            done = 1'b1; lat = c; rdata = dbg_rdata;
         end
      end
      dbg_req = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL dbg_timeout: no O_dbg_ack within 20 cycles, required an ack");
      end
      @(negedge clk);
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      int          busy_low_at = 0;
      int          bad = 0;
      bit          saw_ack = 1'b0;
      logic [31:0] exp_rd;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || state !== 2'd0) begin
         n_fail++; $display("FAIL reset_state: busy=%b state=%0d, required busy=1 state=0", busy, state);
      end
      n_checks++;
      if (rf_we !== 1'b0 || rf_re !== 1'b0 || rf_rd !== 5'd0 || rf_rs1 !== 5'd0 || rf_data !== 32'd0) begin
         n_fail++; $display("FAIL reset_rf: we=%b re=%b rd=%0d rs1=%0d data=%h, required all 0",
                            rf_we, rf_re, rf_rd, rf_rs1, rf_data);
      end
      n_checks++;
      if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0 || cpu_regval1 !== 32'd0 || dbg_rdata !== 32'd0) begin
         n_fail++; $display("FAIL reset_acks: cpu_ack=%b dbg_ack=%b regval1=%h rdata=%h, required 0",
                            cpu_ack, dbg_ack, cpu_regval1, dbg_rdata);
      end
      for (int k = 1; k <= 31; k++) exp_q.push_back(32'(k));
      // A CPU request during CLEAR must be left waiting.
      cpu_we = 1'b0; cpu_rs1 = 5'd1; cpu_rs2 = 5'd2; cpu_req = 1'b1;
      rst = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (cpu_ack || dbg_ack) saw_ack = 1'b1;
         if (c == 30) cpu_req = 1'b0;
         if (c <= 31) begin
            exp_rd = exp_q.pop_front();
            n_checks++;
            if (rf_we !== 1'b1 || rf_re !== 1'b0 || rf_rd !== exp_rd[4:0] || rf_data !== 32'd0) begin
               n_fail++; $display("FAIL clear_step%0d: we=%b re=%b rd=%0d data=%h, required we=1 re=0 rd=%0d data=0",
                                  c, rf_we, rf_re, rf_rd, rf_data, exp_rd);
            end
         end else if (c == 32) begin
            n_checks++;
            if (rf_we !== 1'b0) begin
               n_fail++; $display("FAIL clear_end_we: we=%b, required 0 after x31", rf_we);
            end
         end
         if (busy_low_at == 0 && busy === 1'b0) busy_low_at = c;
      end
      n_checks++;
      if (busy_low_at != 32) begin
         n_fail++; $display("FAIL clear_busy_len: busy fell %0d cycles after release, required 32", busy_low_at);
      end
      n_checks++;
      if (saw_ack) begin
         n_fail++; $display("FAIL clear_no_ack: ack seen during CLEAR, required none");
      end
      for (int k = 1; k < 32; k++) if (regs[k] !== 32'd0) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL clear_regs: %0d registers non-zero after CLEAR, required 0", bad);
      end
   endtask

   task automatic test_dbg_write_cpu_read();
      logic [31:0] rd, v1, v2;
      int lat;
      dbg_access(1'b1, 5'd5, 32'hDEADBEEF, rd, lat);
      n_checks++;
      if (snap_we !== 1'b1 || snap_re !== 1'b0 || snap_rd !== 5'd5 || snap_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL dbgwr_rf: we=%b re=%b rd=%0d data=%h, required we=1 re=0 rd=5 data=deadbeef",
                            snap_we, snap_re, snap_rd, snap_data);
      end
      n_checks++;
      if (rd !== 32'd0 || lat != 2) begin
         n_fail++; $display("FAIL dbgwr_ack: rdata=%h lat=%0d, required rdata=0 lat=2", rd, lat);
      end
      cpu_access(1'b0, 5'd5, 5'd0, 5'd0, 32'd0, v1, v2, lat);
      n_checks++;
      if (lat != 2) begin
         n_fail++; $display("FAIL cpu_latency: ack %0d cycles after request, required 2", lat);
      end
      n_checks++;
      if (v1 !== 32'hDEADBEEF || v2 !== 32'd0) begin
         n_fail++; $display("FAIL cpu_read_x5: regval1=%h regval2=%h, required deadbeef 0", v1, v2);
      end
      n_checks++;
      if (snap_re !== 1'b1 || snap_we !== 1'b0 || snap_rs1 !== 5'd5 || snap_rs2 !== 5'd0) begin
         n_fail++; $display("FAIL cpu_read_rf: re=%b we=%b rs1=%0d rs2=%0d, required re=1 we=0 rs1=5 rs2=0",
                            snap_re, snap_we, snap_rs1, snap_rs2);
      end
      n_checks++;
      if (cpu_ack !== 1'b0 || cpu_regval1 !== 32'd0) begin
         n_fail++; $display("FAIL ack_pulse: ack=%b regval1=%h after ack cycle, required 0 0", cpu_ack, cpu_regval1);
      end
   endtask

   task automatic test_read_during_write();
      logic [31:0] rd, v1, v2;
      int lat;
      dbg_access(1'b1, 5'd7, 32'h00000055, rd, lat);
      cpu_access(1'b1, 5'd7, 5'd0, 5'd7, 32'h00001234, v1, v2, lat);
      n_checks++;
      if (v1 !== 32'h00000055 || v2 !== 32'd0) begin
         n_fail++; $display("FAIL rdw_old: regval1=%h regval2=%h, required 00000055 0", v1, v2);
      end
      n_checks++;
      if (snap_re !== 1'b1 || snap_we !== 1'b1 || snap_rd !== 5'd7 || snap_data !== 32'h00001234) begin
         n_fail++; $display("FAIL rdw_rf: re=%b we=%b rd=%0d data=%h, required 1 1 7 00001234",
                            snap_re, snap_we, snap_rd, snap_data);
      end
      cpu_access(1'b0, 5'd7, 5'd7, 5'd0, 32'd0, v1, v2, lat);
      n_checks++;
      if (v1 !== 32'h00001234 || v2 !== 32'h00001234) begin
         n_fail++; $display("FAIL rdw_new: regval1=%h regval2=%h, required 00001234 00001234", v1, v2);
      end
      dbg_access(1'b0, 5'd7, 32'd0, rd, lat);
      n_checks++;
      if (rd !== 32'h00001234 || snap_re !== 1'b1 || snap_we !== 1'b0 || snap_rs1 !== 5'd7) begin
         n_fail++; $display("FAIL dbg_read_x7: rdata=%h re=%b we=%b rs1=%0d, required 00001234 1 0 7",
                            rd, snap_re, snap_we, snap_rs1);
      end
   endtask

   task automatic test_starvation();
      int          acks = 0;
      int          last = 0;
      logic [31:0] exp_g;
      cpu_we = 1'b0; cpu_rs1 = 5'd7; cpu_rs2 = 5'd5; cpu_req = 1'b1;
      dbg_we = 1'b0; dbg_addr = 5'd5; dbg_req = 1'b1;
      exp_q = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
      for (int c = 1; c <= 40 && acks < 6; c++) begin
         @(negedge clk);
         if (cpu_ack && dbg_ack) begin
            n_checks++; n_fail++; $display("FAIL arb_both_ack: both acks high at cycle %0d, required one", c);
         end
         if (cpu_ack || dbg_ack) begin
            exp_g = exp_q.pop_front();
            n_checks++;
            if ({31'd0, dbg_ack} !== exp_g) begin
               n_fail++; $display("FAIL arb_order%0d: dbg_ack=%b, required dbg grant=%0d", acks, dbg_ack, exp_g);
            end
            n_checks++;
            if ((c - last) != ((acks == 0) ? 2 : 3)) begin
               n_fail++; $display("FAIL arb_rate%0d: spacing %0d cycles, required %0d",
                                  acks, c - last, (acks == 0) ? 2 : 3);
            end
            n_checks++;
            if (dbg_ack) begin
               if (dbg_rdata !== 32'hDEADBEEF) begin
                  n_fail++; $display("FAIL arb_dbg_data: rdata=%h, required deadbeef", dbg_rdata);
               end
               dbg_req = 1'b0;
            end else if (cpu_regval1 !== 32'h00001234 || cpu_regval2 !== 32'hDEADBEEF) begin
               n_fail++; $display("FAIL arb_cpu_data: regval1=%h regval2=%h, required 00001234 deadbeef",
                                  cpu_regval1, cpu_regval2);
            end
            acks++;
            last = c;
            if (acks == 6) cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      n_checks++;
      if (acks != 6) begin
         n_fail++; $display("FAIL arb_timeout: %0d acks seen, required 6", acks);
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_x0();
      logic [31:0] rd;
      int lat;
      dbg_access(1'b1, 5'd0, 32'hFFFFFFFF, rd, lat);
      n_checks++;
      if (snap_we !== 1'b1 || snap_rd !== 5'd0 || snap_data !== 32'hFFFFFFFF || rd !== 32'd0) begin
         n_fail++; $display("FAIL x0_write: we=%b rd=%0d data=%h rdata=%h, required 1 0 ffffffff 0",
                            snap_we, snap_rd, snap_data, rd);
      end
      dbg_access(1'b0, 5'd0, 32'd0, rd, lat);
      n_checks++;
      if (rd !== 32'd0) begin
         n_fail++; $display("FAIL x0_read: rdata=%h, required 0", rd);
      end
   endtask

   task automatic test_reset_in_access();
      int busy_low_at = 0;
      bit saw_ack = 1'b0;
      cpu_we = 1'b1; cpu_rs1 = 5'd5; cpu_rs2 = 5'd0; cpu_rd = 5'd9; cpu_data = 32'h00000999; cpu_req = 1'b1;
      @(negedge clk);
      n_checks++;
      if (state !== 2'd2 || rf_we !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre: state=%0d we=%b, required ACCESS(2) we=1", state, rf_we);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (rf_re !== 1'b0 || rf_we !== 1'b0 || rf_rd !== 5'd0 || state !== 2'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_async: re=%b we=%b rd=%0d state=%0d busy=%b, required 0 0 0 0 1",
                            rf_re, rf_we, rf_rd, state, busy);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (cpu_ack || dbg_ack) saw_ack = 1'b1;
         if (c == 1) begin
            n_checks++;
            if (rf_we !== 1'b1 || rf_rd !== 5'd1) begin
               n_fail++; $display("FAIL rst_clear_restart: we=%b rd=%0d, required we=1 rd=1", rf_we, rf_rd);
            end
         end
         if (busy_low_at == 0 && busy === 1'b0) busy_low_at = c;
      end
      n_checks++;
      if (saw_ack || busy_low_at != 32) begin
         n_fail++; $display("FAIL rst_drop: ack_seen=%b busy fell at %0d, required no ack and 32", saw_ack, busy_low_at);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      @(negedge clk);
      test_reset();
      test_dbg_write_cpu_read();
      test_read_during_write();
      test_starvation();
      test_x0();
      test_reset_in_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
